// File: rtl/egress_pkg.sv
// Shared definitions for the egress serializer: FSM encoding, frame geometry
// and destination codes, plus the frame-building helper.
package egress_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_LOAD  = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

  localparam int FRAME_W     = 8;
  localparam int SHIFT_CNT_W = 3;

  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

  // Frame layout is {dest, even parity over the payload, payload[5:0]}.
  function automatic logic [FRAME_W-1:0] make_frame(input logic dest,
                                                    input logic [5:0] payload);
    return {dest, ^payload, payload};
  endfunction

endpackage

// File: rtl/serializer_piso.sv
// Parallel-in serial-out shift register; emits the MSB first and shifts
// toward it, filling with zeros.
module serializer_piso
  import egress_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [FRAME_W-1:0] din,
  output logic               msb
);

  logic [FRAME_W-1:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh <= '0;
    end else if (load) begin
      sh <= din;
    end else if (shift) begin
      sh <= {sh[FRAME_W-2:0], 1'b0};
    end
  end

  assign msb = sh[FRAME_W-1];

endmodule

// File: rtl/egress_serializer.sv
// Round-robin drain of two destination FIFOs into one MSB-first serial frame
// stream, with per-destination saturating frame counters.
module egress_serializer
  import egress_pkg::*;
#(
  parameter int data_width  = 6,
  parameter int count_width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   empty_fifo_D0,
  input  logic                   empty_fifo_D1,
  input  logic [data_width-1:0]  data_out_D0,
  input  logic [data_width-1:0]  data_out_D1,
  output logic                   D0_pop,
  output logic                   D1_pop,
  output logic                   serial_out,
  output logic                   serial_valid,
  output logic                   frame_start,
  output logic                   idle_out,
  output logic [count_width-1:0] count_D0,
  output logic [count_width-1:0] count_D1,
  output logic [1:0]             fsm_state
);

  // FIFO handshake: empty=0 means a word is available; a one-cycle pop
  // consumes it and the word is presented on data_out the following cycle.
  // serial_valid qualifies serial_out; there is no backpressure on the stream.

  state_t                 state, next_state;
  logic                   sel;
  logic                   last_served;
  logic [SHIFT_CNT_W-1:0] bit_cnt;
  logic                   pick;
  logic                   any_ready;
  logic                   last_bit;
  logic                   decide;
  logic [5:0]             payload;
  logic                   piso_msb;

  assign any_ready = ~empty_fifo_D0 | ~empty_fifo_D1;
  assign last_bit  = (state == ST_SHIFT) && (bit_cnt == SHIFT_CNT_W'(FRAME_W - 1));
  // Empty flags only matter at these two decision points.
  assign decide    = enable && any_ready && ((state == ST_IDLE) || last_bit);

  always_comb begin
    pick = DEST_D0;
    if (last_served == DEST_D1) begin
      pick = empty_fifo_D0 ? DEST_D1 : DEST_D0;
    end else begin
      pick = empty_fifo_D1 ? DEST_D0 : DEST_D1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (decide) next_state = ST_POP;
      ST_POP:   next_state = ST_LOAD;
      ST_LOAD:  next_state = ST_SHIFT;
      ST_SHIFT: if (last_bit) next_state = decide ? ST_POP : ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      sel         <= DEST_D0;
      last_served <= DEST_D1;
      bit_cnt     <= '0;
    end else begin
      state <= next_state;
      if (decide) begin
        sel         <= pick;
        last_served <= pick;
      end
      if (state == ST_LOAD) begin
        bit_cnt <= '0;
      end else if (state == ST_SHIFT) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_D0 <= '0;
      count_D1 <= '0;
    end else if (state == ST_LOAD) begin
      if (sel == DEST_D0 && count_D0 != '1) count_D0 <= count_D0 + 1'b1;
      if (sel == DEST_D1 && count_D1 != '1) count_D1 <= count_D1 + 1'b1;
    end
  end

  assign payload = (sel == DEST_D1) ? data_out_D1[5:0] : data_out_D0[5:0];

  serializer_piso u_piso (
    .clk   (clk),
    .rst   (reset),
    .load  (state == ST_LOAD),
    .shift (state == ST_SHIFT),
    .din   (make_frame(sel, payload)),
    .msb   (piso_msb)
  );

  assign D0_pop       = (state == ST_POP) && (sel == DEST_D0);
  assign D1_pop       = (state == ST_POP) && (sel == DEST_D1);
  assign serial_valid = (state == ST_SHIFT);
  assign serial_out   = (state == ST_SHIFT) && piso_msb;
  assign frame_start  = (state == ST_SHIFT) && (bit_cnt == '0);
  assign idle_out     = (state == ST_IDLE);
  assign fsm_state    = state;

endmodule
